// File: rtl/seg8_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg8_scan_driver
// Brief    : Scans a 64-bit active-low segment word onto an 8-digit display,
//            one digit per slot, with a blanking gap and a per-frame latch.
// Revision : 1.0 - initial release
// ============================================================================
module seg8_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] seg_in,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [2:0]  scan_idx,
    output logic        frame_done
);

    localparam int            c_cw           = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cw-1:0] c_cnt_last   = c_cw'(SCAN_DIV - 1);
    localparam logic [c_cw-1:0] c_blank_cnt  = c_cw'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    logic [c_cw-1:0] r_cnt;
    logic [2:0]      r_scan_idx;
    logic            r_started;
    logic [63:0]     r_shadow;
    logic            r_frame_done;
    state_t          r_state;
    logic [7:0]      r_an;
    logic [7:0]      r_seg;

    logic            w_slot_end;
    logic            w_frame_end;
    logic            w_in_blank;
    logic            w_latch;
    logic [7:0]      w_digit_an;
    logic [7:0]      w_digit_seg;
    state_t          w_state_nxt;
    logic [7:0]      w_an_nxt;
    logic [7:0]      w_seg_nxt;

    assign w_slot_end  = (r_cnt == c_cnt_last);
    assign w_frame_end = w_slot_end && (r_scan_idx == 3'd7);
    assign w_in_blank  = (r_cnt < c_blank_cnt);
    assign w_latch     = !r_started || w_frame_end;
    assign w_digit_an  = ~(8'b1 << r_scan_idx);
    assign w_digit_seg = r_shadow[{r_scan_idx, 3'b000} +: 8];

    // Slot counter, digit index and frame shadow; shadow survives en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_scan_idx   <= 3'd0;
            r_started    <= 1'b0;
            r_shadow     <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            r_cnt        <= '0;
            r_scan_idx   <= 3'd0;
            r_started    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_started    <= 1'b1;
            r_frame_done <= w_frame_end;
            if (w_latch) begin
                r_shadow <= seg_in;
            end
            if (w_slot_end) begin
                r_cnt      <= '0;
                r_scan_idx <= r_scan_idx + 3'd1;
            end else begin
                r_cnt      <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OFF;
            r_an    <= 8'hFF;
            r_seg   <= 8'hFF;
        end else begin
            r_state <= w_state_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    // Leaving OFF always lands at cnt 0, which is inside the blank window.
    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = 8'hFF;
        w_seg_nxt   = 8'hFF;
        if (!en) begin
            w_state_nxt = S_OFF;
        end else begin
            unique case (r_state)
                S_OFF:   w_state_nxt = S_BLANK;
                S_BLANK: w_state_nxt = w_in_blank ? S_BLANK : S_DRIVE;
                S_DRIVE: w_state_nxt = w_in_blank ? S_BLANK : S_DRIVE;
                default: w_state_nxt = S_OFF;
            endcase
        end
        if (w_state_nxt == S_DRIVE) begin
            w_an_nxt  = w_digit_an;
            w_seg_nxt = w_digit_seg;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign scan_idx   = r_scan_idx;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
